// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller:
// FSM state encoding, the NOP injected while fetch is stalled, and word size.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Program-loader side of the controller: start/base/count command, the
// valid/ready word stream, and the load status flags.
interface imem_load_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [ADDR_WIDTH-2:0] load_count;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_busy;
  logic                  load_done;
  logic                  load_err;

  modport master (
    output load_start, load_base, load_count, load_valid, load_data,
    input  load_ready, load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, load_base, load_count, load_valid, load_data,
    output load_ready, load_busy, load_done, load_err
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Arbitrates the single-port instruction memory between core fetch (IDLE)
// and a loader burst that writes consecutive words while fetch is stalled.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic [DATA_WIDTH-1:0] fetch_instr_o,
  output logic                  fetch_stall_o,
  imem_load_ctrl_if.slave       ld,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-2:0] r_remaining;
  logic                  r_err;

  logic [ADDR_WIDTH:0]   w_end;
  logic [ADDR_WIDTH:0]   w_limit;
  logic                  w_reject;
  logic                  w_accept;

  // End of the burst is checked one bit wider so a wrap past the top is caught.
  assign w_end    = {1'b0, ld.load_base} + {ld.load_count, 2'b00};
  assign w_limit  = {1'b1, {ADDR_WIDTH{1'b0}}};
  assign w_reject = (ld.load_base[1:0] != 2'b00) || (w_end > w_limit);
  assign w_accept = (r_state == LOAD) && ld.load_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld.load_start) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_err       <= 1'b0;
              r_ptr       <= ld.load_base;
              r_remaining <= ld.load_count;
              r_state     <= (ld.load_count == '0) ? DONE : LOAD;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_ptr       <= r_ptr + ADDR_WIDTH'(WORD_BYTES);
            r_remaining <= r_remaining - (ADDR_WIDTH-1)'(1);
            if (r_remaining == (ADDR_WIDTH-1)'(1)) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Everything below decodes from registered state only; start never leaks through.
  always_comb begin
    fetch_instr_o = mem_rdata_i;
    fetch_stall_o = 1'b0;
    mem_addr_o    = fetch_addr_i;
    mem_we_o      = 1'b0;
    ld.load_ready = 1'b0;
    ld.load_done  = 1'b0;
    case (r_state)
      LOAD: begin
        fetch_instr_o = DATA_WIDTH'(NOP_INSTR);
        fetch_stall_o = 1'b1;
        mem_addr_o    = r_ptr;
        mem_we_o      = ld.load_valid;
        ld.load_ready = 1'b1;
      end
      DONE: begin
        fetch_instr_o = DATA_WIDTH'(NOP_INSTR);
        fetch_stall_o = 1'b1;
        mem_addr_o    = r_ptr;
        ld.load_done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_wdata_o  = ld.load_data;
  assign ld.load_busy = (r_state != IDLE);
  assign ld.load_err  = r_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural instruction memory;
// expected writes are queued at stimulus time and matched by a write monitor.
module tb_imem_load_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_instr;
  logic          fetch_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;

  imem_load_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lif ();

  imem_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_addr_i (fetch_addr),
    .fetch_instr_o(fetch_instr),
    .fetch_stall_o(fetch_stall),
    .ld           (lif.slave),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW-2:0] cnt);
    lif.load_start = 1'b1;
    lif.load_base  = base;
    lif.load_count = cnt;
  endtask

  // Write monitor: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        check("wr_data", mem_wdata, mon_e.d);
      end
    end
    if (lif.load_done) n_done++;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | i;
    fetch_addr     = 10'h010;
    lif.load_start = 1'b0;
    lif.load_base  = '0;
    lif.load_count = '0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;

    // Reset passthrough
    #2;
    check("rst_addr",  32'(mem_addr), 32'h010);
    check("rst_instr", fetch_instr, 32'h5A00_0004);
    check("rst_stall", 32'(fetch_stall), 0);
    check("rst_busy",  32'(lif.load_busy), 0);
    check("rst_ready", 32'(lif.load_ready), 0);
    check("rst_done",  32'(lif.load_done), 0);
    check("rst_err",   32'(lif.load_err), 0);
    check("rst_we",    32'(mem_we), 0);
    cyc(); cyc();
    rst = 1'b0;

    // Basic load: base 0x020, count 3, continuous valid
    cyc();
    start(10'h020, 9'd3);
    lif.load_valid = 1'b1; lif.load_data = 32'hAAAA_0001;
    push(10'h020, 32'hAAAA_0001); push(10'h024, 32'hBBBB_0002); push(10'h028, 32'hCCCC_0003);
    cyc(); lif.load_start = 1'b0;
    @(negedge clk);
    check("ld_busy",  32'(lif.load_busy), 1);
    check("ld_stall", 32'(fetch_stall), 1);
    check("ld_ready", 32'(lif.load_ready), 1);
    check("ld_nop",   fetch_instr, NOP);
    cyc(); lif.load_data = 32'hBBBB_0002;
    cyc(); lif.load_data = 32'hCCCC_0003;
    @(negedge clk);
    check("ld_c3_done", 32'(lif.load_done), 0);
    cyc(); lif.load_valid = 1'b0;
    @(negedge clk);
    check("ld_done",       32'(lif.load_done), 1);
    check("ld_done_ready", 32'(lif.load_ready), 0);
    check("ld_done_stall", 32'(fetch_stall), 1);
    check("ld_done_nop",   fetch_instr, NOP);
    cyc(); fetch_addr = 10'h024;
    @(negedge clk);
    check("ld_c5_stall", 32'(fetch_stall), 0);
    check("ld_c5_busy",  32'(lif.load_busy), 0);
    check("ld_fetchB",   fetch_instr, 32'hBBBB_0002);

    // Gapped valid: base 0x040, two idle cycles after the first word
    cyc();
    start(10'h040, 9'd3);
    lif.load_valid = 1'b1; lif.load_data = 32'hDDDD_0004;
    push(10'h040, 32'hDDDD_0004); push(10'h044, 32'hEEEE_0005); push(10'h048, 32'hFFFF_0006);
    cyc(); lif.load_start = 1'b0;
    cyc(); lif.load_valid = 1'b0;
    @(negedge clk);
    check("gap_we",    32'(mem_we), 0);
    check("gap_ready", 32'(lif.load_ready), 1);
    cyc();
    cyc(); lif.load_valid = 1'b1; lif.load_data = 32'hEEEE_0005;
    cyc(); lif.load_data = 32'hFFFF_0006;
    @(negedge clk);
    check("gap_c5_done", 32'(lif.load_done), 0);
    cyc(); lif.load_valid = 1'b0;
    @(negedge clk);
    check("gap_c6_done", 32'(lif.load_done), 1);
    cyc();
    @(negedge clk);
    check("gap_c7_busy", 32'(lif.load_busy), 0);

    // Rejects and acceptance at the very top of memory
    cyc(); start(10'h022, 9'd1); lif.load_valid = 1'b1; lif.load_data = 32'h1111_1111;
    cyc(); lif.load_start = 1'b0;
    @(negedge clk);
    check("rej_mis_err",  32'(lif.load_err), 1);
    check("rej_mis_busy", 32'(lif.load_busy), 0);
    cyc(); start(10'h3FC, 9'd1); lif.load_data = 32'h9999_0007;
    push(10'h3FC, 32'h9999_0007);
    cyc(); lif.load_start = 1'b0;
    @(negedge clk);
    check("top_ok_err",  32'(lif.load_err), 0);
    check("top_ok_busy", 32'(lif.load_busy), 1);
    cyc(); lif.load_valid = 1'b0;
    @(negedge clk);
    check("top_ok_done", 32'(lif.load_done), 1);
    cyc(); start(10'h3FC, 9'd2); lif.load_valid = 1'b1;
    cyc(); lif.load_start = 1'b0;
    @(negedge clk);
    check("rej_ovf_err",  32'(lif.load_err), 1);
    check("rej_ovf_busy", 32'(lif.load_busy), 0);
    check("rej_ovf_done", 32'(lif.load_done), 0);
    lif.load_valid = 1'b0;

    // Zero-count load goes straight to DONE
    cyc(); start(10'h080, 9'd0);
    cyc(); lif.load_start = 1'b0;
    @(negedge clk);
    check("zero_done",  32'(lif.load_done), 1);
    check("zero_busy",  32'(lif.load_busy), 1);
    check("zero_ready", 32'(lif.load_ready), 0);
    check("zero_err",   32'(lif.load_err), 0);
    cyc();
    @(negedge clk);
    check("zero_idle", 32'(lif.load_busy), 0);

    // Start held during LOAD with different base/count is ignored
    cyc(); start(10'h100, 9'd2);
    push(10'h100, 32'h7777_0008); push(10'h104, 32'h8888_0009);
    cyc(); start(10'h200, 9'd5);
    @(negedge clk);
    check("ign_busy", 32'(lif.load_busy), 1);
    cyc(); lif.load_start = 1'b0; lif.load_valid = 1'b1; lif.load_data = 32'h7777_0008;
    cyc(); lif.load_data = 32'h8888_0009;
    cyc(); lif.load_valid = 1'b0;
    @(negedge clk);
    check("ign_done", 32'(lif.load_done), 1);
    cyc();
    @(negedge clk);
    check("ign_idle", 32'(lif.load_busy), 0);

    // Reset after 2 of 5 words
    cyc(); start(10'h180, 9'd5); lif.load_valid = 1'b1; lif.load_data = 32'hC0DE_0000;
    push(10'h180, 32'hC0DE_0000); push(10'h184, 32'hC0DE_0001);
    cyc(); lif.load_start = 1'b0;
    cyc(); lif.load_data = 32'hC0DE_0001;
    cyc(); lif.load_data = 32'hC0DE_0002;
    #1 rst = 1'b1;
    #1;
    check("mid_busy",  32'(lif.load_busy), 0);
    check("mid_stall", 32'(fetch_stall), 0);
    check("mid_ready", 32'(lif.load_ready), 0);
    check("mid_we",    32'(mem_we), 0);
    check("mid_done",  32'(lif.load_done), 0);
    cyc(); cyc();
    rst = 1'b0; lif.load_valid = 1'b0;
    @(negedge clk);
    check("mid_after_done", 32'(lif.load_done), 0);
    check("mid_mem0", mem[96],  32'hC0DE_0000);
    check("mid_mem1", mem[97],  32'hC0DE_0001);
    check("mid_mem2", mem[98],  32'h5A00_0062);
    check("mid_mem3", mem[99],  32'h5A00_0063);
    check("mid_mem4", mem[100], 32'h5A00_0064);

    // Reset clears a sticky error
    cyc(); start(10'h002, 9'd1);
    cyc(); lif.load_start = 1'b0;
    @(negedge clk);
    check("err_set", 32'(lif.load_err), 1);
    #1 rst = 1'b1;
    #1;
    check("err_rst", 32'(lif.load_err), 0);
    cyc(); rst = 1'b0;
    cyc(); cyc();

    check("queue_left", 32'(exp_q.size()), 0);
    check("done_count", 32'(n_done), 5);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
